// File: rtl/seg14_scan_driver_pkg.sv
// Shared definitions for the 14-segment scan driver: default sizes, FSM states
// and a small set of glyph codes (bit order a,b,c,d,e,f,g1,g2,h,i,j,k,l,m).
package seg14_scan_driver_pkg;

    localparam int SEG14_DIGITS = 12;
    localparam int SEG14_SEGS   = 14;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_e;

    localparam logic [13:0] GLYPH_SPACE = 14'h0000;
    localparam logic [13:0] GLYPH_0     = 14'h0C3F;
    localparam logic [13:0] GLYPH_1     = 14'h0006;
    localparam logic [13:0] GLYPH_2     = 14'h00DB;
    localparam logic [13:0] GLYPH_3     = 14'h008F;
    localparam logic [13:0] GLYPH_A     = 14'h00F7;
    localparam logic [13:0] GLYPH_E     = 14'h00F9;
    localparam logic [13:0] GLYPH_H     = 14'h00F6;
    localparam logic [13:0] GLYPH_L     = 14'h0038;
    localparam logic [13:0] GLYPH_O     = 14'h003F;

endpackage

// File: rtl/seg14_frame_buf.sv
// Tear-free digit store: the sequencer writes the shadow copy, and the whole
// shadow is copied into the scanned (active) copy in one edge at frame end.
module seg14_frame_buf
    import seg14_scan_driver_pkg::*;
#(
    parameter int DIGITS = SEG14_DIGITS,
    parameter int SEGS   = SEG14_SEGS,
    parameter int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIGITS-1:0] in_sel_i,
    input  logic [SEGS-1:0]   in_segm_i,
    input  logic              in_valid_i,
    input  logic              swap_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [SEGS-1:0]   rd_segm_o,
    output logic              sel_err_o
);

    logic [SEGS-1:0]   shadow_q [DIGITS];
    logic [SEGS-1:0]   active_q [DIGITS];
    logic              sel_err_q;
    logic              oneHot;
    logic              multiHot;
    logic [DIGITS-1:0] wrEn;

    // A select with exactly one bit set has no bits left after clearing its lowest one.
    always_comb begin
        oneHot   = (in_sel_i != '0) && ((in_sel_i & (in_sel_i - DIGITS'(1))) == '0);
        multiHot = in_valid_i && (in_sel_i != '0) && !oneHot;
        wrEn     = (in_valid_i && oneHot) ? in_sel_i : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            sel_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (wrEn[i]) begin
                    shadow_q[i] <= in_segm_i;
                end
                // A write landing on the swap edge must not be lost from the active copy.
                if (swap_i) begin
                    active_q[i] <= wrEn[i] ? in_segm_i : shadow_q[i];
                end
            end
            sel_err_q <= multiHot;
        end
    end

    assign rd_segm_o = active_q[rd_idx_i];
    assign sel_err_o = sel_err_q;

endmodule

// File: rtl/seg14_scan_driver.sv
// Multiplexed 14-segment scan driver: blank, then show each digit in turn with
// PWM dimming; every pad-facing output comes straight from a register.
module seg14_scan_driver
    import seg14_scan_driver_pkg::*;
#(
    parameter int DIGITS      = SEG14_DIGITS,
    parameter int SEGS        = SEG14_SEGS,
    parameter int DWELL_W     = 16,
    parameter int DWELL_CYC   = 50000,
    parameter int BLANK_CYC   = 500,
    parameter int PWM_W       = 4,
    parameter int COM_ACT_LOW = 0,
    parameter int SEG_ACT_LOW = 0
) (
`ifdef USE_POWER_PINS
    inout  wire               vdd,
    inout  wire               vss,
`endif
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIGITS-1:0] in_sel,
    input  logic [SEGS-1:0]   in_segm,
    input  logic              in_valid,
    input  logic              en,
    input  logic [PWM_W-1:0]  brightness,
    output logic [DIGITS-1:0] dig_out,
    output logic [SEGS-1:0]   seg_out,
    output logic              frame_done,
    output logic              sel_err
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIGITS-1:0] DIG_OFF = (COM_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [SEGS-1:0]   SEG_OFF = (SEG_ACT_LOW != 0) ? {SEGS{1'b1}} : {SEGS{1'b0}};
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYC - 1);
    localparam logic [DWELL_W-1:0] BLANK_LAST = DWELL_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [PWM_W-1:0]   pwm_q;
    logic [DIGITS-1:0]  dig_q, dig_d;
    logic [SEGS-1:0]    seg_q, seg_d;
    logic               frameDone_q;
    logic               endFrame;
    logic               showing;
    logic               pwmOn;
    logic [SEGS-1:0]    activeSegm;

    seg14_frame_buf #(
        .DIGITS (DIGITS),
        .SEGS   (SEGS),
        .IDX_W  (IDX_W)
    ) u_frameBuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_sel_i   (in_sel),
        .in_segm_i  (in_segm),
        .in_valid_i (in_valid),
        .swap_i     (endFrame),
        .rd_idx_i   (idx_q),
        .rd_segm_o  (activeSegm),
        .sel_err_o  (sel_err)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        dwell_d  = dwell_q;
        endFrame = 1'b0;
        showing  = 1'b0;
        if (!en) begin
            state_d = S_IDLE;
            idx_d   = '0;
            dwell_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_BLANK;
                    idx_d   = '0;
                    dwell_d = '0;
                end
                S_BLANK: begin
                    if (dwell_q == BLANK_LAST) begin
                        state_d = S_SHOW;
                        dwell_d = '0;
                    end else begin
                        dwell_d = dwell_q + DWELL_W'(1);
                    end
                end
                S_SHOW: begin
                    showing = 1'b1;
                    if (dwell_q == DWELL_LAST) begin
                        state_d = S_BLANK;
                        dwell_d = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d    = '0;
                            endFrame = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        dwell_d = dwell_q + DWELL_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    dwell_d = '0;
                end
            endcase
        end
    end

    // Full-scale brightness bypasses the compare so the segments never flicker off.
    always_comb begin
        pwmOn = (pwm_q < brightness) || (&brightness);
        dig_d = showing ? (DIGITS'(1) << idx_q) : '0;
        seg_d = (showing && pwmOn) ? activeSegm : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            dwell_q     <= '0;
            pwm_q       <= '0;
            dig_q       <= DIG_OFF;
            seg_q       <= SEG_OFF;
            frameDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dwell_q     <= dwell_d;
            pwm_q       <= pwm_q + PWM_W'(1);
            dig_q       <= dig_d ^ DIG_OFF;
            seg_q       <= seg_d ^ SEG_OFF;
            frameDone_q <= endFrame;
        end
    end

    assign dig_out    = dig_q;
    assign seg_out    = seg_q;
    assign frame_done = frameDone_q;

endmodule
